// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, frame constants and parity helper for the uart
// Optional feature macro: UART_PARITY_EN adds an even-parity bit after D7.
// No ports; imported by uart and uart_rx.
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 deserialiser with input synchroniser and one-cycle byte strobe
// Optional feature macro: UART_PARITY_EN (even parity checked, bad bytes dropped).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_rx              serial input, idle high, asynchronous to clk
//   o_rx_byte         last correctly framed byte
//   o_byte_available  one-cycle strobe when o_rx_byte is updated
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_byte_available
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);

    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_avail;
    logic                 r_par_err;

    logic                 w_rx;
    logic                 w_sample;
    uart_state_t          w_state_n;
    logic [CNT_W-1:0]     w_cnt_n;
    logic [IDX_W-1:0]     w_idx_n;
    logic [DATA_BITS-1:0] w_shift_n;
    logic [DATA_BITS-1:0] w_byte_n;
    logic                 w_avail_n;
    logic                 w_par_err_n;

    assign w_rx             = r_sync[1];
    // Counter restarts at the start edge, so HALF lands mid start bit and every
    // later full bit period lands mid data/stop bit.
    assign w_sample         = (r_state == START) ? (r_cnt == HALF) : (r_cnt == LAST);
    assign o_rx_byte        = r_byte;
    assign o_byte_available = r_avail;

    always_comb begin
        w_state_n   = r_state;
        w_idx_n     = r_idx;
        w_shift_n   = r_shift;
        w_byte_n    = r_byte;
        w_avail_n   = 1'b0;
        w_par_err_n = r_par_err;
        case (r_state)
            IDLE:    if (r_rx_prev && !w_rx) w_state_n = START;
            START:   if (w_sample) begin
                         w_state_n   = w_rx ? IDLE : DATA;
                         w_idx_n     = '0;
                         w_par_err_n = 1'b0;
                     end
            DATA:    if (w_sample) begin
                         w_shift_n = {w_rx, r_shift[DATA_BITS-1:1]};
                         w_idx_n   = r_idx + 1'b1;
                         if (r_idx == LAST_BIT) w_state_n = PARITY_EN ? PARITY : STOP;
                     end
            PARITY:  if (w_sample) begin
                         w_par_err_n = w_rx ^ even_parity(r_shift);
                         w_state_n   = STOP;
                     end
            STOP:    if (w_sample) begin
                         // Back in IDLE with rx low after a framing error: re-arming
                         // needs a fresh falling edge, i.e. the line must go high first.
                         w_state_n = IDLE;
                         if (w_rx && !r_par_err) begin
                             w_byte_n  = r_shift;
                             w_avail_n = 1'b1;
                         end
                     end
            default: w_state_n = IDLE;
        endcase
        w_cnt_n = (r_state == IDLE || w_sample) ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_avail   <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_rx_prev <= w_rx;
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_idx     <= w_idx_n;
            r_shift   <= w_shift_n;
            r_byte    <= w_byte_n;
            r_avail   <= w_avail_n;
            r_par_err <= w_par_err_n;
        end
    end
endmodule

// File: rtl/uart.sv
// uart: full-duplex 8N1 UART, transmitter and baud timing here, receiver in uart_rx
// Optional feature macro: UART_PARITY_EN (even parity after D7, 11-bit frames).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rx, tx          serial in (asynchronous, idle high) / serial out (idle high)
//   tx_byte         byte latched when a request is accepted
//   send_request    one-cycle request, accepted only while busy is low
//   busy            high for the whole transmit frame
//   rx_byte         last correctly framed received byte
//   byte_available  one-cycle strobe on rx_byte update
module uart
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_byte,
    input  logic                 send_request,
    output logic                 busy,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_available
);
    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_bit_end;
    uart_state_t          w_state_n;
    logic [CNT_W-1:0]     w_cnt_n;
    logic [IDX_W-1:0]     w_idx_n;
    logic [DATA_BITS-1:0] w_data_n;
    logic                 w_tx_n;
    logic                 w_busy_n;

    assign w_bit_end = (r_cnt == LAST);
    assign tx        = r_tx;
    assign busy      = r_busy;

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_data_n  = r_data;
        case (r_state)
            IDLE:    if (send_request && !r_busy) begin
                         w_state_n = START;
                         w_data_n  = tx_byte;
                     end
            START:   if (w_bit_end) begin
                         w_state_n = DATA;
                         w_idx_n   = '0;
                     end
            DATA:    if (w_bit_end) begin
                         w_idx_n = r_idx + 1'b1;
                         if (r_idx == LAST_BIT) w_state_n = PARITY_EN ? PARITY : STOP;
                     end
            PARITY:  if (w_bit_end) w_state_n = STOP;
            STOP:    if (w_bit_end) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
        w_cnt_n  = (r_state == IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
        // tx and busy are registered from the next state so the pin changes on
        // the same edge the state does, without a combinational path to the pad.
        w_busy_n = (w_state_n != IDLE);
        w_tx_n   = (w_state_n == START)  ? 1'b0 :
                   (w_state_n == DATA)   ? w_data_n[w_idx_n] :
                   (w_state_n == PARITY) ? even_parity(w_data_n) : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_data  <= w_data_n;
            r_tx    <= w_tx_n;
            r_busy  <= w_busy_n;
        end
    end

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_rx             (rx),
        .o_rx_byte        (rx_byte),
        .o_byte_available (byte_available)
    );
endmodule

// File: tb/tb_uart.sv
// tb_uart: scoreboard-driven bench for uart TX, RX, error rejection, loopback and reset
module tb_uart;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int CPB    = 104;
    localparam int LB_CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       send_request = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx, busy, byte_available, rx_line;
    logic [7:0] rx_byte;

    logic       lb_req = 1'b0;
    logic [7:0] lb_byte = 8'h00;
    logic       lb_tx, lb_busy, lb_avail;
    logic [7:0] lb_rx_byte;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int cycle = 0;
    int strobe_cycle = 0;
    logic prev_avail = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] lb_q[$];

    assign rx_line = loop ? tx : rx_drv;

    uart u_dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_line), .tx(tx), .tx_byte(tx_byte),
        .send_request(send_request), .busy(busy), .rx_byte(rx_byte),
        .byte_available(byte_available)
    );

    // Second instance at 8 clocks per bit keeps the 256-byte loopback short.
    uart #(.CLK_HZ(12000000), .BAUD(1500000)) u_lb (
        .clk(clk), .rst_n(rst_n), .rx(lb_tx), .tx(lb_tx), .tx_byte(lb_byte),
        .send_request(lb_req), .busy(lb_busy), .rx_byte(lb_rx_byte),
        .byte_available(lb_avail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin : rx_monitor
        logic [7:0] e;
        if (byte_available === 1'b1) begin
            strobes++;
            strobe_cycle = cycle;
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected_strobe got byte %02h required no strobe", rx_byte);
            end else begin
                e = rx_q.pop_front();
                if (rx_byte !== e) begin
                    errors++;
                    $display("FAIL rx_byte got %02h required %02h", rx_byte, e);
                end
            end
            checks++;
            if (prev_avail === 1'b1) begin
                errors++;
                $display("FAIL rx_strobe_width got >1 cycle required 1 cycle");
            end
        end
        prev_avail = byte_available;
    end

    function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
`ifdef UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic send(input logic [7:0] b);
        tx_byte = b;
        send_request = 1'b1;
        @(negedge clk);
        send_request = 1'b0;
    endtask

    task automatic capture(input int inj_at, input logic [7:0] inj_b,
                           output logic [NB-1:0] bits, output int n);
        n = 0;
        bits = '0;
        while (busy === 1'b1 && n < NB * CPB + 100) begin
            if (n % CPB == CPB / 2 && n / CPB < NB) bits[n / CPB] = tx;
            send_request = (n == inj_at);
            if (n == inj_at) tx_byte = inj_b;
            n++;
            @(negedge clk);
        end
        send_request = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [NB-1:0] f;
        f = frame_bits(b);
        f[NB-1] = stop;
        for (int i = 0; i < NB; i++) begin
            rx_drv = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b required 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++; if (byte_available !== 1'b0) begin errors++; $display("FAIL reset_avail got %b required 0", byte_available); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %02h required 00", rx_byte); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tx;
        logic [NB-1:0] bits;
        int n;
        send(8'h61);
        capture(-1, 8'h00, bits, n);
        checks++; if (bits !== frame_bits(8'h61)) begin errors++; $display("FAIL tx_frame_61 got %b required %b", bits, frame_bits(8'h61)); end
        checks++; if (n !== NB * CPB) begin errors++; $display("FAIL tx_busy_cycles got %0d required %0d", n, NB * CPB); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle_level got %b required 1", tx); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_tx_overlap;
        logic [NB-1:0] bits;
        int n;
        logic hi;
        send(8'hA5);
        capture(500, 8'h3C, bits, n);
        checks++; if (bits !== frame_bits(8'hA5)) begin errors++; $display("FAIL overlap_frame got %b required %b", bits, frame_bits(8'hA5)); end
        checks++; if (n !== NB * CPB) begin errors++; $display("FAIL overlap_busy_cycles got %0d required %0d", n, NB * CPB); end
        send(8'h96);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b required 1", busy); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start_bit got %b required 0", tx); end
        capture(-1, 8'h00, bits, n);
        checks++; if (bits !== frame_bits(8'h96)) begin errors++; $display("FAIL b2b_frame got %b required %b", bits, frame_bits(8'h96)); end
        checks++; if (n !== NB * CPB) begin errors++; $display("FAIL b2b_busy_cycles got %0d required %0d", n, NB * CPB); end
        hi = 1'b0;
        repeat (2 * CPB) begin
            @(negedge clk);
            if (busy !== 1'b0) hi = 1'b1;
        end
        checks++; if (hi !== 1'b0) begin errors++; $display("FAIL ignored_request_queued got busy 1 required 0"); end
    endtask

    task automatic test_rx;
        int s0, c0, d, ex;
        s0 = strobes;
        @(negedge clk);
        c0 = cycle;
        rx_q.push_back(8'h2A);
        drive_frame(8'h2A, 1'b1);
        repeat (20) @(negedge clk);
        d = strobe_cycle - c0;
        ex = (2 * NB - 1) * CPB / 2;
        checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL rx_strobe_count got %0d required 1", strobes - s0); end
        checks++; if (d < ex - 8 || d > ex + 12) begin errors++; $display("FAIL rx_strobe_time got %0d required about %0d", d, ex); end
        checks++; if (rx_byte !== 8'h2A) begin errors++; $display("FAIL rx_byte_2a got %02h required 2a", rx_byte); end
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL rx_queue_left got %0d required 0", rx_q.size()); end
    endtask

    task automatic test_rx_errors;
        int s0;
        s0 = strobes;
        rx_drv = 1'b0;
        repeat (30) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        checks++; if (strobes !== s0) begin errors++; $display("FAIL glitch_strobe got %0d required 0", strobes - s0); end
        drive_frame(8'h55, 1'b0);
        repeat (300) @(negedge clk);
        checks++; if (strobes !== s0) begin errors++; $display("FAIL framing_strobe got %0d required 0", strobes - s0); end
        checks++; if (rx_byte !== 8'h2A) begin errors++; $display("FAIL framing_rx_byte got %02h required 2a", rx_byte); end
        rx_q.push_back(8'hC3);
        drive_frame(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL rearm_strobe got %0d required 1", strobes - s0); end
        checks++; if (rx_byte !== 8'hC3) begin errors++; $display("FAIL rearm_rx_byte got %02h required c3", rx_byte); end
    endtask

    task automatic test_loopback;
        int s;
        s = 0;
        for (int b = 0; b < 256; b++) begin
            int t;
            logic [7:0] e;
            lb_q.push_back(8'(b));
            lb_byte = 8'(b);
            lb_req = 1'b1;
            @(negedge clk);
            lb_req = 1'b0;
            t = 0;
            while (lb_avail !== 1'b1 && t < 20 * LB_CPB) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (lb_avail !== 1'b1) begin
                errors++;
                $display("FAIL loop_timeout got no strobe required byte %02h", 8'(b));
            end else begin
                s++;
                e = lb_q.pop_front();
                if (lb_rx_byte !== e) begin
                    errors++;
                    $display("FAIL loop_byte got %02h required %02h", lb_rx_byte, e);
                end
            end
            t = 0;
            while (lb_busy === 1'b1 && t < 20 * LB_CPB) begin
                @(negedge clk);
                t++;
            end
        end
        checks++; if (s !== 256) begin errors++; $display("FAIL loop_strobes got %0d required 256", s); end
    endtask

    task automatic test_reset_midframe;
        int s0;
        loop = 1'b1;
        s0 = strobes;
        send(8'h00);
        repeat (400) @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_tx_before got %b required 0", tx); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midframe_tx_async got %b required 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midframe_busy got %b required 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1200) @(negedge clk);
        checks++; if (strobes !== s0) begin errors++; $display("FAIL midframe_strobe got %0d required 0", strobes - s0); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL midframe_rx_byte got %02h required 00", rx_byte); end
        loop = 1'b0;
    endtask

    initial begin
        test_reset;
        test_tx;
        test_tx_overlap;
        test_rx;
        test_rx_errors;
        test_loopback;
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
